// File: rtl/alu_uart_sequencer_pkg.sv
// Shared definitions for the UART-driven ALU sequencer: default widths,
// the ALU opcode values, and the sequencer state type.
package alu_uart_sequencer_pkg;

  localparam int DEF_BITS_DATO      = 8;
  localparam int DEF_BITS_OPCODE    = 6;
  localparam int DEF_TIMEOUT_CYCLES = 1000000;

  localparam logic [5:0] OP_ADD = 6'b100000;
  localparam logic [5:0] OP_SUB = 6'b100010;
  localparam logic [5:0] OP_AND = 6'b100100;
  localparam logic [5:0] OP_OR  = 6'b100101;
  localparam logic [5:0] OP_XOR = 6'b100110;
  localparam logic [5:0] OP_NOR = 6'b100111;
  localparam logic [5:0] OP_SRA = 6'b000011;
  localparam logic [5:0] OP_SRL = 6'b000010;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_B,
    ST_WAIT_OP,
    ST_EXEC,
    ST_SEND,
    ST_WAIT_TX
  } seq_state_e;

  function automatic logic is_wait_state(input seq_state_e s);
    return (s == ST_WAIT_B) || (s == ST_WAIT_OP);
  endfunction

endpackage

// File: rtl/alu_uart_sequencer_timeout.sv
// Inter-byte timeout counter: counts enabled cycles, clear has priority,
// tc_o flags the cycle in which the count sits at TIMEOUT_CYCLES-1.
module alu_uart_sequencer_timeout
  import alu_uart_sequencer_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic enable_i,
  input  logic clear_i,
  output logic tc_o
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (enable_i) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign tc_o = enable_i && (count_q == LAST_COUNT);

endmodule

// File: rtl/alu_uart_sequencer.sv
// Loads ALU operand A, operand B and opcode from three UART bytes, latches the
// result and hands it to the transmitter. Optional inter-byte timeout: SEQ_TIMEOUT_EN.
module alu_uart_sequencer
  import alu_uart_sequencer_pkg::*;
#(
  parameter int CANT_BITS_DATO   = DEF_BITS_DATO,
  parameter int CANT_BITS_OPCODE = DEF_BITS_OPCODE,
  parameter int TIMEOUT_CYCLES   = DEF_TIMEOUT_CYCLES
) (
  input  logic                        i_clock,
  input  logic                        i_reset,
  input  logic                        i_rx_done,
  input  logic [CANT_BITS_DATO-1:0]   i_rx_data,
  input  logic [CANT_BITS_DATO-1:0]   i_alu_result,
  input  logic                        i_tx_done,
  output logic [CANT_BITS_DATO-1:0]   o_reg_dato_A,
  output logic [CANT_BITS_DATO-1:0]   o_reg_dato_B,
  output logic [CANT_BITS_OPCODE-1:0] o_reg_opcode,
  output logic                        o_tx_start,
  output logic [CANT_BITS_DATO-1:0]   o_tx_data,
  output logic                        o_busy,
  output logic                        o_drop,
  output logic                        o_timeout
);

  seq_state_e                  state_q, state_d;
  logic [CANT_BITS_DATO-1:0]   dato_a_q, dato_a_d;
  logic [CANT_BITS_DATO-1:0]   dato_b_q, dato_b_d;
  logic [CANT_BITS_OPCODE-1:0] opcode_q, opcode_d;
  logic [CANT_BITS_DATO-1:0]   tx_data_q, tx_data_d;
  logic                        byte_drop;
  logic                        tmo_fire;
  logic                        tmo_tc;

`ifdef SEQ_TIMEOUT_EN
  logic tmo_clear;

  // Every accepted byte restarts the inter-byte window, including the one that enters WAIT_B.
  assign tmo_clear = i_rx_done &&
                     (state_q == ST_IDLE || state_q == ST_WAIT_B || state_q == ST_WAIT_OP);

  alu_uart_sequencer_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk_i   (i_clock),
    .rst_ni  (i_reset),
    .enable_i(is_wait_state(state_q)),
    .clear_i (tmo_clear),
    .tc_o    (tmo_tc)
  );
`else
  assign tmo_tc = 1'b0;
`endif

  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      state_q   <= ST_IDLE;
      dato_a_q  <= '0;
      dato_b_q  <= '0;
      opcode_q  <= '0;
      tx_data_q <= '0;
    end else begin
      state_q   <= state_d;
      dato_a_q  <= dato_a_d;
      dato_b_q  <= dato_b_d;
      opcode_q  <= opcode_d;
      tx_data_q <= tx_data_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    dato_a_d  = dato_a_q;
    dato_b_d  = dato_b_q;
    opcode_d  = opcode_q;
    tx_data_d = tx_data_q;
    byte_drop = 1'b0;
    tmo_fire  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (i_rx_done) begin
          dato_a_d = i_rx_data;
          state_d  = ST_WAIT_B;
        end
      end
      ST_WAIT_B: begin
        if (i_rx_done) begin
          dato_b_d = i_rx_data;
          state_d  = ST_WAIT_OP;
        end else if (tmo_tc) begin
          tmo_fire = 1'b1;
          state_d  = ST_IDLE;
        end
      end
      ST_WAIT_OP: begin
        if (i_rx_done) begin
          opcode_d = i_rx_data[CANT_BITS_OPCODE-1:0];
          state_d  = ST_EXEC;
        end else if (tmo_tc) begin
          tmo_fire = 1'b1;
          state_d  = ST_IDLE;
        end
      end
      // Operands were registered last cycle, so the ALU output has settled by now.
      ST_EXEC: begin
        tx_data_d = i_alu_result;
        byte_drop = i_rx_done;
        state_d   = ST_SEND;
      end
      ST_SEND: begin
        byte_drop = i_rx_done;
        state_d   = ST_WAIT_TX;
      end
      ST_WAIT_TX: begin
        byte_drop = i_rx_done;
        if (i_tx_done) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign o_reg_dato_A = dato_a_q;
  assign o_reg_dato_B = dato_b_q;
  assign o_reg_opcode = opcode_q;
  assign o_tx_data    = tx_data_q;
  assign o_tx_start   = (state_q == ST_SEND);
  assign o_busy       = (state_q != ST_IDLE);
  assign o_drop       = byte_drop;
  assign o_timeout    = tmo_fire;

endmodule

// File: tb/tb_alu_uart_sequencer.sv
// Scoreboard bench for alu_uart_sequencer: stimulus pushes expected results,
// a negedge monitor pops and checks them whenever o_tx_start is seen.
module tb_alu_uart_sequencer;
  import alu_uart_sequencer_pkg::*;

  localparam int TB_TIMEOUT = 16;

  logic       i_clock = 1'b0;
  logic       i_reset;
  logic       i_rx_done;
  logic [7:0] i_rx_data;
  logic [7:0] i_alu_result;
  logic       i_tx_done;
  logic [7:0] o_reg_dato_A;
  logic [7:0] o_reg_dato_B;
  logic [5:0] o_reg_opcode;
  logic       o_tx_start;
  logic [7:0] o_tx_data;
  logic       o_busy;
  logic       o_drop;
  logic       o_timeout;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [5:0] op;
    logic [7:0] res;
    int         startCycle;
  } exp_t;

  exp_t sbq[$];
  exp_t mon;

  int tests       = 0;
  int failed      = 0;
  int cycle       = 0;
  int dropSeen    = 0;
  int expDrops    = 0;
  int timeoutSeen = 0;
  int expTimeouts = 0;
  bit monOn       = 1'b0;

  logic [5:0] opList [8] = '{OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_NOR, OP_SRA, OP_SRL};

  alu_uart_sequencer #(
    .CANT_BITS_DATO  (8),
    .CANT_BITS_OPCODE(6),
    .TIMEOUT_CYCLES  (TB_TIMEOUT)
  ) dut (
    .i_clock     (i_clock),
    .i_reset     (i_reset),
    .i_rx_done   (i_rx_done),
    .i_rx_data   (i_rx_data),
    .i_alu_result(i_alu_result),
    .i_tx_done   (i_tx_done),
    .o_reg_dato_A(o_reg_dato_A),
    .o_reg_dato_B(o_reg_dato_B),
    .o_reg_opcode(o_reg_opcode),
    .o_tx_start  (o_tx_start),
    .o_tx_data   (o_tx_data),
    .o_busy      (o_busy),
    .o_drop      (o_drop),
    .o_timeout   (o_timeout)
  );

  always #5 i_clock = ~i_clock;

  always @(posedge i_clock) cycle <= cycle + 1;

  // Behavioural ALU, used both as the DUT's environment and as the reference.
  function automatic logic [7:0] aluFn(input logic [7:0] a, input logic [7:0] b,
                                       input logic [5:0] op);
    case (op)
      OP_ADD:  return a + b;
      OP_SUB:  return a - b;
      OP_AND:  return a & b;
      OP_OR:   return a | b;
      OP_XOR:  return a ^ b;
      OP_NOR:  return ~(a | b);
      OP_SRA:  return $unsigned($signed(a) >>> b[2:0]);
      OP_SRL:  return a >> b[2:0];
      default: return 8'h00;
    endcase
  endfunction

  assign i_alu_result = aluFn(o_reg_dato_A, o_reg_dato_B, o_reg_opcode);

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    tests++;
    if (actual !== expected) begin
      failed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Monitor: counts pulses and checks each transmitted result against the scoreboard.
  always @(negedge i_clock) begin
    if (monOn) begin
      if (o_drop === 1'b1) dropSeen++;
      if (o_timeout === 1'b1) timeoutSeen++;
      if (o_tx_start === 1'b1) begin
        if (sbq.size() == 0) begin
          tests++;
          failed++;
          $display("[TB] FAIL unexpected_tx_start: got o_tx_start at cycle %0d, expected none", cycle);
        end else begin
          mon = sbq.pop_front();
          checkOutput("tx_data", o_tx_data, mon.res);
          checkOutput("reg_A", o_reg_dato_A, mon.a);
          checkOutput("reg_B", o_reg_dato_B, mon.b);
          checkOutput("reg_opcode", o_reg_opcode, mon.op);
          checkOutput("tx_start_cycle", cycle, mon.startCycle);
        end
      end
    end
  end

  // One stimulus cycle: inputs change 1 time unit after the rising edge.
  task automatic applyStimulus(input logic rx, input logic [7:0] data, input logic tx);
    @(posedge i_clock);
    #1;
    i_rx_done = rx;
    i_rx_data = rx ? data : 8'($urandom);
    i_tx_done = tx;
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_A"}, o_reg_dato_A, 0);
    checkOutput({tag, "_B"}, o_reg_dato_B, 0);
    checkOutput({tag, "_opcode"}, o_reg_opcode, 0);
    checkOutput({tag, "_tx_data"}, o_tx_data, 0);
    checkOutput({tag, "_tx_start"}, o_tx_start, 0);
    checkOutput({tag, "_busy"}, o_busy, 0);
    checkOutput({tag, "_drop"}, o_drop, 0);
    checkOutput({tag, "_timeout"}, o_timeout, 0);
  endtask

  task automatic issueTxn(input logic [7:0] a, input logic [7:0] b, input logic [7:0] opByte,
                          input int mode, input int gap1, input int gap2, output exp_t e);
    e.a   = a;
    e.b   = b;
    e.op  = opByte[5:0];
    e.res = aluFn(a, b, opByte[5:0]);
    applyStimulus(1'b1, a, 1'b0);
    repeat (gap1) applyStimulus(1'b0, 8'h00, mode == 4);
    applyStimulus(1'b1, b, 1'b0);
    repeat (gap2) applyStimulus(1'b0, 8'h00, 1'b0);
    applyStimulus(1'b1, opByte, 1'b0);
    e.startCycle = cycle + 2;
    sbq.push_back(e);
    if (mode == 3) begin
      applyStimulus(1'b1, 8'($urandom), 1'b0);
      expDrops++;
    end
    applyStimulus(1'b0, 8'h00, 1'b0);
  endtask

  task automatic completeTxn(input exp_t e, input int mode);
    bit found;
    int d;
    found = 1'b0;
    for (int i = 0; i < 8 && !found; i++) begin
      @(negedge i_clock);
      if (o_tx_start === 1'b1) found = 1'b1;
    end
    if (!found) begin
      tests++;
      failed++;
      $display("[TB] FAIL tx_start_wait: got no o_tx_start, expected one within 8 cycles");
      sbq.delete();
      @(posedge i_clock); #1; i_reset = 1'b0;
      @(posedge i_clock); #1; i_reset = 1'b1;
      expDrops = dropSeen;
      return;
    end
    d = $urandom_range(0, 3);
    repeat (d) applyStimulus(1'b0, 8'h00, 1'b0);
    if (mode == 1) begin
      applyStimulus(1'b1, 8'($urandom), 1'b0);
      expDrops++;
      @(negedge i_clock);
      checkOutput("wait_tx_busy", o_busy, 1);
      checkOutput("drop_keeps_A", o_reg_dato_A, e.a);
      checkOutput("drop_keeps_B", o_reg_dato_B, e.b);
      checkOutput("drop_keeps_opcode", o_reg_opcode, e.op);
      applyStimulus(1'b0, 8'h00, 1'b1);
    end else if (mode == 2) begin
      applyStimulus(1'b1, 8'($urandom), 1'b1);
      expDrops++;
    end else begin
      applyStimulus(1'b0, 8'h00, 1'b1);
    end
    applyStimulus(1'b0, 8'h00, 1'b0);
    @(negedge i_clock);
    checkOutput("busy_after_tx_done", o_busy, 0);
    checkOutput("drop_count", dropSeen, expDrops);
    checkOutput("hold_A", o_reg_dato_A, e.a);
    checkOutput("hold_B", o_reg_dato_B, e.b);
    checkOutput("hold_opcode", o_reg_opcode, e.op);
    checkOutput("hold_tx_data", o_tx_data, e.res);
  endtask

  task automatic runTxn(input logic [7:0] a, input logic [7:0] b, input logic [7:0] opByte,
                        input int mode, input int gap1, input int gap2);
    exp_t e;
    issueTxn(a, b, opByte, mode, gap1, gap2, e);
    completeTxn(e, mode);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int mode;
    int prev;
    exp_t e;
    i_reset   = 1'b0;
    i_rx_done = 1'b0;
    i_rx_data = 8'h00;
    i_tx_done = 1'b0;
    repeat (3) @(posedge i_clock);
    #1;
    i_reset = 1'b1;
    @(negedge i_clock);
    checkAllZero("reset");
    monOn = 1'b1;

    // Basic add, then the same add with junk in the opcode byte's upper bits.
    runTxn(8'h05, 8'h03, 8'h20, 0, 0, 0);
    runTxn(8'h05, 8'h03, 8'hE0, 0, 0, 0);

    // Bytes arriving while the result is being sent.
    runTxn(8'h40, 8'h0F, 8'h26, 1, 1, 2);
    runTxn(8'hC3, 8'h5A, 8'h24, 2, 0, 1);
    runTxn(8'hF0, 8'h20, 8'h22, 3, 2, 0);
    runTxn(8'h81, 8'h03, 8'h03, 4, 2, 1);

    // Reset in the middle of a load, then a fresh sequence.
    applyStimulus(1'b1, 8'h11, 1'b0);
    applyStimulus(1'b1, 8'h22, 1'b0);
    @(posedge i_clock); #1;
    i_rx_done = 1'b0;
    i_reset   = 1'b0;
    @(posedge i_clock); #1;
    i_reset = 1'b1;
    @(negedge i_clock);
    checkAllZero("mid_reset");
    runTxn(8'h19, 8'h27, 8'h20, 0, 1, 1);

`ifdef SEQ_TIMEOUT_EN
    // One byte then silence: the window closes after TB_TIMEOUT cycles in WAIT_B.
    prev = timeoutSeen;
    applyStimulus(1'b1, 8'h77, 1'b0);
    repeat (TB_TIMEOUT) applyStimulus(1'b0, 8'h00, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b0);
    @(negedge i_clock);
    expTimeouts++;
    checkOutput("timeout_busy", o_busy, 0);
    checkOutput("timeout_pulse", timeoutSeen, prev + 1);
    checkOutput("timeout_keeps_A", o_reg_dato_A, 8'h77);
    runTxn(8'h5A, 8'h21, 8'h20, 0, 0, 0);

    // Second byte lands exactly on the terminal cycle and wins over the timeout.
    prev  = timeoutSeen;
    e.a   = 8'h12;
    e.b   = 8'h34;
    e.op  = OP_ADD;
    e.res = aluFn(8'h12, 8'h34, OP_ADD);
    applyStimulus(1'b1, 8'h12, 1'b0);
    repeat (TB_TIMEOUT - 1) applyStimulus(1'b0, 8'h00, 1'b0);
    applyStimulus(1'b1, 8'h34, 1'b0);
    applyStimulus(1'b1, {2'b00, OP_ADD}, 1'b0);
    e.startCycle = cycle + 2;
    sbq.push_back(e);
    applyStimulus(1'b0, 8'h00, 1'b0);
    completeTxn(e, 0);
    checkOutput("terminal_no_timeout", timeoutSeen, prev);
`else
    prev = 0;
    e.startCycle = 0;
`endif

    for (int t = 0; t < 40; t++) begin
      mode = $urandom_range(0, 4);
      runTxn(8'($urandom), 8'($urandom),
             {2'($urandom), opList[$urandom_range(0, 7)]},
             mode, $urandom_range((mode == 4) ? 1 : 0, 3), $urandom_range(0, 3));
    end

    repeat (3) applyStimulus(1'b0, 8'h00, 1'b0);
    @(negedge i_clock);
    checkOutput("timeout_count", timeoutSeen, expTimeouts);
    checkOutput("scoreboard_empty", sbq.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
